// File: rtl/reward_timer_if.sv
// Pickup event channel from the item-collection logic into the reward timer.
interface reward_timer_if;
   logic       pickup_valid;
   logic [1:0] pickup_type;

   modport master (output pickup_valid, output pickup_type);
   modport slave  (input  pickup_valid, input  pickup_type);
endinterface

// File: rtl/reward_timer.sv
// Holds the single active power-up reward for DURATION one-second ticks and
// exports the one-hot reward flags plus the elapsed-second count.
module reward_timer #(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int DURATION    = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable_reward,
   input  logic               pause,
   reward_timer_if.slave      pickup,
   output logic [9:0]         reward_cnt,
   output logic               reward_invincible,
   output logic               reward_frozen,
   output logic               reward_faster,
   output logic               reward_laser,
   output logic               reward_expired
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [9:0]    CNT_LAST   = 10'(DURATION - 1);
   localparam logic [9:0]    CNT_END    = 10'(DURATION);

   typedef enum logic [1:0] {IDLE, ACTIVE, EXPIRE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [9:0]    cnt_q, cnt_d;
   logic [3:0]    flags_q, flags_d;
   logic          expired_q, expired_d;
   logic          take_pickup;
   logic          tick;

   assign take_pickup = enable_reward && pickup.pickup_valid;
   assign tick        = (state_q == ACTIVE) && !pause && (presc_q == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         flags_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         flags_q   <= flags_d;
         expired_q <= expired_d;
      end
   end

   // Priority: abort, then pickup, then the natural lifetime of the reward.
   always_comb begin
      state_d = state_q;
      if (!enable_reward) begin
         state_d = IDLE;
      end else if (take_pickup) begin
         state_d = ACTIVE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            ACTIVE:  if (tick && cnt_q == CNT_LAST) state_d = EXPIRE;
            EXPIRE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered outputs are computed one cycle ahead so they stay glitch-free.
   always_comb begin
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      flags_d   = flags_q;
      expired_d = 1'b0;
      if (!enable_reward) begin
         presc_d = '0;
         cnt_d   = '0;
         flags_d = '0;
      end else if (take_pickup) begin
         presc_d = '0;
         cnt_d   = '0;
         flags_d = 4'b0001 << pickup.pickup_type;
      end else begin
         unique case (state_q)
            ACTIVE: begin
               if (!pause) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_d = '0;
                     if (cnt_q == CNT_LAST) begin
                        cnt_d     = CNT_END;
                        flags_d   = '0;
                        expired_d = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 10'd1;
                     end
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
            end
            default: begin
               presc_d = '0;
               cnt_d   = '0;
               flags_d = '0;
            end
         endcase
      end
   end

   assign reward_cnt        = cnt_q;
   assign reward_invincible = flags_q[0];
   assign reward_frozen     = flags_q[1];
   assign reward_faster     = flags_q[2];
   assign reward_laser      = flags_q[3];
   assign reward_expired    = expired_q;

endmodule

// File: tb/tb_reward_timer.sv
// Directed bench for reward_timer: lifetime, refresh, pause, abort, pickup on
// the expiry tick, and a long-duration smoke instance.
module tb_reward_timer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable_reward;
   logic       pause;
   logic       mon_on = 1'b0;

   logic [9:0] r_cnt;
   logic       r_inv, r_frz, r_fst, r_lsr, r_exp;
   logic [9:0] s_cnt;
   logic       s_inv, s_frz, s_fst, s_lsr, s_exp;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int          n;

   reward_timer_if pu  ();
   reward_timer_if pu2 ();

   always #5 clk = ~clk;

   reward_timer #(.TICK_CYCLES(4), .DURATION(3)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable_reward     (enable_reward),
      .pause             (pause),
      .pickup            (pu.slave),
      .reward_cnt        (r_cnt),
      .reward_invincible (r_inv),
      .reward_frozen     (r_frz),
      .reward_faster     (r_fst),
      .reward_laser      (r_lsr),
      .reward_expired    (r_exp)
   );

   reward_timer #(.TICK_CYCLES(2), .DURATION(20)) dut_long (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable_reward     (enable_reward),
      .pause             (pause),
      .pickup            (pu2.slave),
      .reward_cnt        (s_cnt),
      .reward_invincible (s_inv),
      .reward_frozen     (s_frz),
      .reward_faster     (s_fst),
      .reward_laser      (s_lsr),
      .reward_expired    (s_exp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic pickup(input logic [1:0] t);
      pu.pickup_valid = 1'b1;
      pu.pickup_type  = t;
      step();
      pu.pickup_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cnt"},   32'(r_cnt), 0);
      check({tag, "_flags"}, 32'({r_lsr, r_fst, r_frz, r_inv}), 0);
      check({tag, "_exp"},   32'(r_exp), 0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check("onehot", 32'($onehot0({r_lsr, r_fst, r_frz, r_inv})), 1);
         check("onehot_long", 32'($onehot0({s_lsr, s_fst, s_frz, s_inv})), 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b0;
      enable_reward    = 1'b1;
      pause            = 1'b0;
      pu.pickup_valid  = 1'b0;
      pu.pickup_type   = 2'd0;
      pu2.pickup_valid = 1'b0;
      pu2.pickup_type  = 2'd0;
      step();
      step();
      check_idle("reset");
      rst_n = 1'b1;
      step();
      mon_on = 1'b1;

      // Asynchronous reset while a reward is active
      pickup(2'd3);
      repeat (5) step();
      check("pre_rst_cnt", 32'(r_cnt), 1);
      check("pre_rst_lsr", 32'(r_lsr), 1);
      #2 rst_n = 1'b0;
      #1 check_idle("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_idle("post_rst");

      // Basic lifetime, laser
      pickup(2'd3);
      for (int k = 0; k < 12; k++) begin
         check("life_lsr", 32'(r_lsr), 1);
         check("life_cnt", 32'(r_cnt), 32'(k / 4));
         check("life_exp", 32'(r_exp), 0);
         step();
      end
      check("exp_lsr", 32'(r_lsr), 0);
      check("exp_pulse", 32'(r_exp), 1);
      check("exp_cnt", 32'(r_cnt), 3);
      step();
      check_idle("after_exp");

      // Refresh with a different type
      pickup(2'd1);
      repeat (5) step();
      check("ref_pre_cnt", 32'(r_cnt), 1);
      check("ref_pre_frz", 32'(r_frz), 1);
      pickup(2'd2);
      check("ref_frz", 32'(r_frz), 0);
      check("ref_fst", 32'(r_fst), 1);
      check("ref_cnt", 32'(r_cnt), 0);
      n = 0;
      while (r_fst && n < 40) begin
         n++;
         step();
      end
      check("ref_len", 32'(n), 12);
      check("ref_exp", 32'(r_exp), 1);
      step();

      // Pause for 10 edges while reward_cnt = 1
      pickup(2'd0);
      n = 0;
      while (r_inv && n < 60) begin
         if (n >= 5 && n <= 14) check("pause_cnt", 32'(r_cnt), 1);
         if (n == 4)  pause = 1'b1;
         if (n == 14) pause = 1'b0;
         n++;
         step();
      end
      check("pause_len", 32'(n), 22);
      check("pause_exp", 32'(r_exp), 1);
      check("pause_exp_cnt", 32'(r_cnt), 3);
      step();

      // Abort at reward_cnt = 2, then a pickup while disabled
      pickup(2'd2);
      repeat (8) step();
      check("abort_pre_cnt", 32'(r_cnt), 2);
      enable_reward = 1'b0;
      step();
      check_idle("abort");
      pickup(2'd1);
      check_idle("dis_pickup");
      repeat (3) begin
         step();
         check("abort_noexp", 32'(r_exp), 0);
      end
      enable_reward = 1'b1;
      step();
      check_idle("reenable");

      // Pickup coinciding with the expiry tick
      pickup(2'd3);
      repeat (11) step();
      check("tie_pre_cnt", 32'(r_cnt), 2);
      pickup(2'd0);
      check("tie_exp", 32'(r_exp), 0);
      check("tie_cnt", 32'(r_cnt), 0);
      check("tie_inv", 32'(r_inv), 1);
      check("tie_lsr", 32'(r_lsr), 0);
      step();
      check("tie_exp2", 32'(r_exp), 0);
      check("tie_cnt2", 32'(r_cnt), 0);
      enable_reward = 1'b0;
      step();
      enable_reward = 1'b1;
      step();
      check_idle("tie_clear");

      // Long-duration instance: DURATION 20, TICK_CYCLES 2
      pu2.pickup_valid = 1'b1;
      pu2.pickup_type  = 2'd2;
      step();
      pu2.pickup_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         check("long_cnt", 32'(s_cnt), 32'(k / 2));
         check("long_fst", 32'(s_fst), 1);
         check("long_exp", 32'(s_exp), 0);
         step();
      end
      check("long_end_cnt", 32'(s_cnt), 20);
      check("long_end_exp", 32'(s_exp), 1);
      check("long_end_fst", 32'(s_fst), 0);
      step();
      check("long_idle_cnt", 32'(s_cnt), 0);
      check("long_idle_exp", 32'(s_exp), 0);

      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reward_timer.md
Name: reward_timer

Overview:
- Owns the lifetime of the single active power-up reward (invincible / frozen / faster / laser).
- Latches a pickup event, holds the matching one-hot reward flag for DURATION seconds, and exports the elapsed-seconds count.
- Sits directly upstream of the reward information overlay, which draws the remaining-time bar and the reward icon from these outputs.
- Also feeds the tank and enemy logic with the reward flags.

Parameters:
- TICK_CYCLES, 100_000_000, clk cycles per one-second tick; legal range 2 and above.
- DURATION, 20, reward lifetime in seconds; legal range 1 to 1023.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable_reward  input  1  game running; low aborts any reward.
- pause  input  1  freezes the prescaler and the count while high.
- pickup_valid  input  1  single-cycle pulse: a reward item was collected.
- pickup_type  input  2  reward type, sampled with pickup_valid: 0 = invincible, 1 = frozen, 2 = faster, 3 = laser.
- reward_cnt  output  10  elapsed whole seconds of the current reward.
- reward_invincible  output  1  invincible reward active.
- reward_frozen  output  1  frozen reward active.
- reward_faster  output  1  faster reward active.
- reward_laser  output  1  laser reward active.
- reward_expired  output  1  one-cycle pulse when a reward times out naturally.

Behaviour:
- Reset: all outputs registered and cleared asynchronously on rst_n low. State = IDLE, prescaler = 0, reward_cnt = 0, all four flags 0, reward_expired 0.
- FSM states:
  - IDLE: no reward held.
  - ACTIVE: reward held, timing.
  - EXPIRE: one cycle, flags already cleared.
- Pickup rule: on a clk edge where enable_reward = 1 and pickup_valid = 1, the following take effect next cycle, from any state:
  - state goes to ACTIVE;
  - prescaler = 0 and reward_cnt = 0;
  - exactly the flag selected by pickup_type is 1 and the other three are 0.
- Refresh: a pickup while ACTIVE replaces the type and restarts the full DURATION. No stacking.
- Prescaler: counts only in ACTIVE with pause = 0.
  - At TICK_CYCLES-1 it wraps to 0 and generates a tick.
  - A tick increments reward_cnt.
  - reward_cnt is 10 bits, unsigned, and never exceeds DURATION.
- Expiry: a tick with reward_cnt == DURATION-1 moves the FSM to EXPIRE.
  - In EXPIRE: reward_cnt = DURATION, all flags 0, reward_expired = 1 for exactly that cycle.
  - Next cycle: IDLE, reward_cnt = 0, reward_expired = 0.
- Flag timing: flags are 1 for exactly DURATION*TICK_CYCLES cycles after a pickup, given no pause, refresh or abort.
- Pause: prescaler and reward_cnt hold and flags stay asserted. Pickups are still accepted while paused and restart the count.
- Abort: enable_reward = 0 on any edge sends the FSM to IDLE next cycle.
  - reward_cnt = 0, flags 0, prescaler 0.
  - No reward_expired pulse.
  - pickup_valid is ignored while enable_reward = 0.
- Simultaneous pickup and expiry tick: pickup wins. The FSM goes to ACTIVE with reward_cnt 0 and no reward_expired pulse.
- Simultaneous pickup and enable_reward = 0: abort wins.
- Pickup in EXPIRE: accepted and goes to ACTIVE. The expired pulse of that cycle has already been issued.
- Invariant: at most one reward flag is 1 at any time. All flags are 0 outside ACTIVE.
- Output timing: every output changes only on clk edges or on asynchronous reset. Outputs are glitch-free registers consumed by the VGA-domain overlay on the same clk.

Test Plan (TICK_CYCLES = 4, DURATION = 3 unless stated):
- Reset and basic lifetime: rst_n low mid-simulation with the FSM ACTIVE, then released; pickup_type 3 pulse.
  - During reset, all outputs read 0 immediately (asynchronous), not at the next edge.
  - After the pickup, reward_laser = 1 for exactly 12 cycles.
  - reward_cnt steps 0, 1, 2 every 4 cycles and reads 3 in the EXPIRE cycle.
  - reward_expired pulses 1 cycle, then reward_cnt = 0.
- Refresh: pickup type 1 at t0; pickup type 2 at t0+6 while reward_cnt = 1.
  - At t0+7: reward_frozen = 0, reward_faster = 1, reward_cnt = 0.
  - reward_faster stays 1 for 12 more cycles.
- Pause: pickup type 0, then pause high for 10 cycles while reward_cnt = 1.
  - reward_cnt and reward_invincible hold.
  - Total asserted time is 22 cycles.
- Abort: pickup type 2, then enable_reward low at reward_cnt = 2.
  - Next cycle: all flags 0, reward_cnt 0, no reward_expired pulse.
  - A pickup_valid while enable_reward = 0 produces no change.
- Pickup on the expiry tick: pickup coincides with the tick at reward_cnt = 2.
  - No reward_expired pulse.
  - reward_cnt = 0 and the new flag is set.
- Default parameters, smoke test: DURATION = 20 with TICK_CYCLES overridden to 2.
  - reward_cnt reaches 19 and then 20 in the EXPIRE cycle only.
  - One-hot invariant checked by assertion every cycle.
